// File: rtl/halt_ctrl_if.sv
// Commit-side observation and halt-report handshake between the core, the halt
// controller and the simulation harness.
interface halt_ctrl_if;
    logic        commit_valid;
    logic [31:0] commit_inst;
    logic [63:0] commit_pc;
    logic [63:0] commit_a0;
    logic        lsu_busy;
    logic        stall;
    logic        halt_valid;
    logic        halt_ready;
    logic [63:0] halt_code;
    logic [63:0] halt_pc;
    logic [63:0] halt_cycles;
    logic [1:0]  halt_cause;
    logic        halted;

    // Core/harness side
    modport master (
        output commit_valid, commit_inst, commit_pc, commit_a0, lsu_busy, halt_ready,
        input  stall, halt_valid, halt_code, halt_pc, halt_cycles, halt_cause, halted
    );

    // Halt controller side
    modport slave (
        input  commit_valid, commit_inst, commit_pc, commit_a0, lsu_busy, halt_ready,
        output stall, halt_valid, halt_code, halt_pc, halt_cycles, halt_cause, halted
    );
endinterface

// File: rtl/halt_ctrl.sv
// Halt controller: freezes the core on a committed ebreak, waits for the LSU to
// drain (bounded by a timeout) and hands a one-shot halt report to the harness.
module halt_ctrl #(
    parameter logic [31:0] EBREAK_INST   = 32'h00100073,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    halt_ctrl_if.slave  hc
);

    localparam int unsigned DCW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_TIMEOUT - 1);

    localparam logic [1:0] CAUSE_CLEAN   = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_REPORT = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [63:0]     cycle_cnt;
    logic [DCW-1:0]  drain_cnt;
    logic [DCW-1:0]  drain_cnt_next;
    logic            capture;
    logic            cause_ld;
    logic [1:0]      cause_val;

    logic [63:0]     code_q;
    logic [63:0]     pc_q;
    logic [63:0]     cycles_q;
    logic [1:0]      cause_q;
    logic            stall_q;
    logic            valid_q;
    logic            halted_q;

    // Next-state and capture decode
    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        capture        = 1'b0;
        cause_ld       = 1'b0;
        cause_val      = CAUSE_CLEAN;
        case (state)
            S_RUN: begin
                if (hc.commit_valid && (hc.commit_inst == EBREAK_INST)) begin
                    capture        = 1'b1;
                    drain_cnt_next = '0;
                    state_next     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A clean drain takes priority over a coincident timeout.
                if (!hc.lsu_busy) begin
                    cause_ld   = 1'b1;
                    cause_val  = CAUSE_CLEAN;
                    state_next = S_REPORT;
                end else if (drain_cnt == DRAIN_LAST) begin
                    cause_ld   = 1'b1;
                    cause_val  = CAUSE_TIMEOUT;
                    state_next = S_REPORT;
                end else begin
                    drain_cnt_next = drain_cnt + DCW'(1);
                end
            end
            S_REPORT: begin
                if (valid_q && hc.halt_ready) begin
                    state_next = S_HALTED;
                end
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_RUN;
            end
        endcase
    end

    // State, counters and report registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_RUN;
            cycle_cnt <= '0;
            drain_cnt <= '0;
            code_q    <= '0;
            pc_q      <= '0;
            cycles_q  <= '0;
            cause_q   <= CAUSE_CLEAN;
            stall_q   <= 1'b0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
            if (state == S_RUN) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (capture) begin
                code_q   <= hc.commit_a0;
                pc_q     <= hc.commit_pc;
                cycles_q <= cycle_cnt;
            end
            if (cause_ld) begin
                cause_q <= cause_val;
            end
            // Status flags track the state register exactly, one flop each.
            stall_q  <= (state_next != S_RUN);
            valid_q  <= (state_next == S_REPORT);
            halted_q <= (state_next == S_HALTED);
        end
    end

    assign hc.stall       = stall_q;
    assign hc.halt_valid  = valid_q;
    assign hc.halt_code   = code_q;
    assign hc.halt_pc     = pc_q;
    assign hc.halt_cycles = cycles_q;
    assign hc.halt_cause  = cause_q;
    assign hc.halted      = halted_q;

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed bench for halt_ctrl: default-timeout instance for the main flows and
// a DRAIN_TIMEOUT=4 instance for the timeout and race cases.
module tb_halt_ctrl;

    localparam logic [31:0] EBREAK = 32'h00100073;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic clock = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clock = ~clock;

    halt_ctrl_if ifa ();
    halt_ctrl_if ifb ();

    halt_ctrl dut_a (
        .clock (clock),
        .reset (reset),
        .hc    (ifa)
    );

    halt_ctrl #(.DRAIN_TIMEOUT(4)) dut_b (
        .clock (clock),
        .reset (reset),
        .hc    (ifb)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic commit_a(input logic v, input logic [31:0] inst,
                            input logic [63:0] pc, input logic [63:0] a0);
        ifa.commit_valid = v;
        ifa.commit_inst  = inst;
        ifa.commit_pc    = pc;
        ifa.commit_a0    = a0;
    endtask

    task automatic commit_b(input logic v, input logic [31:0] inst,
                            input logic [63:0] pc, input logic [63:0] a0);
        ifb.commit_valid = v;
        ifb.commit_inst  = inst;
        ifb.commit_pc    = pc;
        ifb.commit_a0    = a0;
    endtask

    task automatic idle_inputs();
        commit_a(1'b0, 32'd0, 64'd0, 64'd0);
        commit_b(1'b0, 32'd0, 64'd0, 64'd0);
        ifa.lsu_busy   = 1'b0;
        ifa.halt_ready = 1'b0;
        ifb.lsu_busy   = 1'b0;
        ifb.halt_ready = 1'b0;
    endtask

    // Leaves the bench at the negedge that starts cycle 0 after reset release.
    task automatic reset_release();
        @(negedge clock);
        #2 reset = 1'b1;
        idle_inputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check_cleared_a(input string tag);
        check({tag, "_stall"},  64'(ifa.stall),       64'd0);
        check({tag, "_valid"},  64'(ifa.halt_valid),  64'd0);
        check({tag, "_halted"}, 64'(ifa.halted),      64'd0);
        check({tag, "_code"},   ifa.halt_code,        64'd0);
        check({tag, "_pc"},     ifa.halt_pc,          64'd0);
        check({tag, "_cycles"}, ifa.halt_cycles,      64'd0);
        check({tag, "_cause"},  64'(ifa.halt_cause),  64'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        check_cleared_a("rst");
        reset = 1'b0;

        // Clean halt: ten ordinary commits, ebreak at cycle 10
        for (int i = 0; i < 10; i++) begin
            commit_a(1'b1, NOP, 64'h8000_0000 + 64'(4 * i), 64'(i + 3));
            cyc();
        end
        ifa.halt_ready = 1'b1;
        commit_a(1'b1, EBREAK, 64'h8000_0028, 64'd0);
        cyc();
        commit_a(1'b0, NOP, 64'd0, 64'd0);
        check("clean_stall_t1", 64'(ifa.stall),      64'd1);
        check("clean_valid_t1", 64'(ifa.halt_valid), 64'd0);
        cyc();
        check("clean_valid_t2",  64'(ifa.halt_valid), 64'd1);
        check("clean_code",      ifa.halt_code,       64'd0);
        check("clean_pc",        ifa.halt_pc,         64'h8000_0028);
        check("clean_cause",     64'(ifa.halt_cause), 64'd0);
        check("clean_cycles",    ifa.halt_cycles,     64'd10);
        check("clean_halted_t2", 64'(ifa.halted),     64'd0);
        cyc();
        check("clean_halted_t3", 64'(ifa.halted),     64'd1);
        check("clean_valid_t3",  64'(ifa.halt_valid), 64'd0);
        check("clean_stall_t3",  64'(ifa.stall),      64'd1);
        commit_a(1'b1, EBREAK, 64'h8000_0100, 64'd5);
        cyc();
        cyc();
        commit_a(1'b0, NOP, 64'd0, 64'd0);
        check("halted_ignore_valid", 64'(ifa.halt_valid), 64'd0);
        check("halted_ignore_code",  ifa.halt_code,       64'd0);
        check("halted_sticky",       64'(ifa.halted),     64'd1);

        // Drain wait: lsu_busy high for cycles 1..5
        reset_release();
        ifa.lsu_busy   = 1'b1;
        ifa.halt_ready = 1'b1;
        commit_a(1'b1, EBREAK, 64'h8000_0200, 64'd1);
        cyc();
        commit_a(1'b0, NOP, 64'd0, 64'd0);
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("drain_stall_c%0d", k), 64'(ifa.stall),      64'd1);
            check($sformatf("drain_valid_c%0d", k), 64'(ifa.halt_valid), 64'd0);
            if (k == 6) ifa.lsu_busy = 1'b0;
            cyc();
        end
        check("drain_valid_t7", 64'(ifa.halt_valid), 64'd1);
        check("drain_code",     ifa.halt_code,        64'd1);
        check("drain_cause",    64'(ifa.halt_cause),  64'd0);
        check("drain_cycles",   ifa.halt_cycles,      64'd0);
        check("drain_pc",       ifa.halt_pc,          64'h8000_0200);
        cyc();
        check("drain_halted", 64'(ifa.halted), 64'd1);

        // Backpressure: ready low for 20 REPORT cycles, second ebreak presented
        reset_release();
        for (int i = 0; i < 3; i++) begin
            commit_a(1'b1, NOP, 64'h8000_0ff4 + 64'(4 * i), 64'd9);
            cyc();
        end
        commit_a(1'b1, EBREAK, 64'h8000_1000, 64'h55);
        cyc();
        commit_a(1'b1, EBREAK, 64'h8000_2000, 64'hAA);
        cyc();
        for (int k = 0; k < 20; k++) begin
            check($sformatf("bp_valid_%0d", k),  64'(ifa.halt_valid), 64'd1);
            check($sformatf("bp_code_%0d", k),   ifa.halt_code,       64'h55);
            check($sformatf("bp_pc_%0d", k),     ifa.halt_pc,         64'h8000_1000);
            check($sformatf("bp_cycles_%0d", k), ifa.halt_cycles,     64'd3);
            check($sformatf("bp_halted_%0d", k), 64'(ifa.halted),     64'd0);
            if (k == 19) ifa.halt_ready = 1'b1;
            cyc();
        end
        commit_a(1'b0, NOP, 64'd0, 64'd0);
        check("bp_halted_rise", 64'(ifa.halted),     64'd1);
        check("bp_valid_drop",  64'(ifa.halt_valid), 64'd0);
        check("bp_code_final",  ifa.halt_code,       64'h55);
        check("bp_cause_final", 64'(ifa.halt_cause), 64'd0);

        // Reset asserted mid-DRAIN, then a fresh halt
        reset_release();
        ifa.lsu_busy   = 1'b1;
        ifa.halt_ready = 1'b1;
        commit_a(1'b1, NOP, 64'h8000_2ff8, 64'd0);
        cyc();
        commit_a(1'b1, NOP, 64'h8000_2ffc, 64'd0);
        cyc();
        commit_a(1'b1, EBREAK, 64'h8000_3000, 64'h77);
        cyc();
        commit_a(1'b0, NOP, 64'd0, 64'd0);
        check("rdrain_stall_pre", 64'(ifa.stall), 64'd1);
        #2 reset = 1'b1;
        #1 check_cleared_a("rdrain");
        @(negedge clock);
        reset = 1'b0;
        ifa.lsu_busy   = 1'b0;
        ifa.halt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            commit_a(1'b1, NOP, 64'h8000_3ff0 + 64'(4 * i), 64'd0);
            cyc();
        end
        commit_a(1'b1, EBREAK, 64'h8000_4000, 64'h99);
        cyc();
        commit_a(1'b0, NOP, 64'd0, 64'd0);
        cyc();
        check("rdrain_new_valid",  64'(ifa.halt_valid), 64'd1);
        check("rdrain_new_code",   ifa.halt_code,       64'h99);
        check("rdrain_new_pc",     ifa.halt_pc,         64'h8000_4000);
        check("rdrain_new_cycles", ifa.halt_cycles,     64'd4);

        // Reset asserted while REPORT waits on ready, then a fresh halt
        reset_release();
        commit_a(1'b1, EBREAK, 64'h8000_5000, 64'h33);
        cyc();
        commit_a(1'b0, NOP, 64'd0, 64'd0);
        cyc();
        check("rrep_valid_pre", 64'(ifa.halt_valid), 64'd1);
        check("rrep_code_pre",  ifa.halt_code,       64'h33);
        #2 reset = 1'b1;
        #1 check_cleared_a("rrep");
        @(negedge clock);
        reset = 1'b0;
        ifa.halt_ready = 1'b1;
        commit_a(1'b1, NOP, 64'h8000_5ff8, 64'd0);
        cyc();
        commit_a(1'b1, NOP, 64'h8000_5ffc, 64'd0);
        cyc();
        commit_a(1'b1, EBREAK, 64'h8000_6000, 64'h44);
        cyc();
        commit_a(1'b0, NOP, 64'd0, 64'd0);
        cyc();
        check("rrep_new_valid",  64'(ifa.halt_valid), 64'd1);
        check("rrep_new_code",   ifa.halt_code,       64'h44);
        check("rrep_new_cycles", ifa.halt_cycles,     64'd2);
        cyc();
        check("rrep_new_halted", 64'(ifa.halted), 64'd1);

        // Timeout (DRAIN_TIMEOUT=4): lsu_busy stuck high
        reset_release();
        ifb.lsu_busy   = 1'b1;
        ifb.halt_ready = 1'b1;
        commit_b(1'b1, EBREAK, 64'h8000_7000, 64'h12);
        cyc();
        commit_b(1'b0, NOP, 64'd0, 64'd0);
        check("to_stall_t1", 64'(ifb.stall), 64'd1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("to_valid_c%0d", k), 64'(ifb.halt_valid), 64'd0);
            cyc();
        end
        check("to_valid_t5", 64'(ifb.halt_valid), 64'd1);
        check("to_cause",    64'(ifb.halt_cause), 64'd1);
        check("to_code",     ifb.halt_code,       64'h12);
        cyc();
        check("to_halted", 64'(ifb.halted), 64'd1);

        // Race: lsu_busy falls on the cycle the timeout would fire
        reset_release();
        ifb.lsu_busy   = 1'b1;
        ifb.halt_ready = 1'b1;
        commit_b(1'b1, EBREAK, 64'h8000_8000, 64'd0);
        cyc();
        commit_b(1'b0, NOP, 64'd0, 64'd0);
        cyc();
        cyc();
        cyc();
        check("race_valid_t4", 64'(ifb.halt_valid), 64'd0);
        ifb.lsu_busy = 1'b0;
        cyc();
        check("race_valid_t5", 64'(ifb.halt_valid), 64'd1);
        check("race_cause",    64'(ifb.halt_cause), 64'd0);
        check("race_pc",       ifb.halt_pc,         64'h8000_8000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
